uart_tx_buffered: RTL
=====================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLK_FREQ, real, default 100_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, integer, default 115_200: line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, integer, default 16: byte FIFO depth; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port arstn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port tx_data  input  8  byte offered for transmission.
REQ-007 SHALL have port tx_valid  input  1  tx_data valid this cycle.
REQ-008 SHALL have port tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 SHALL have port txd  output  1  serial line, idle high, registered.
REQ-010 SHALL have port tx_busy  output  1  frame in progress.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-012 SHALL use CLKS_PER_BIT = round(CLK_FREQ/BAUD_RATE), computed at elaboration: 868 for defaults.
REQ-013 SHALL accept a byte on any rising edge with tx_valid=1 and tx_ready=1; with tx_ready=0, tx_valid SHALL be ignored.
REQ-014 SHALL drive tx_ready = (fifo_count < FIFO_DEPTH), combinationally from registered count.
REQ-015 SHALL transmit 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit exactly CLKS_PER_BIT cycles.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP with these transitions:
- IDLE -> START when fifo_count > 0 at an edge.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bit periods.
- STOP -> START if fifo_count > 0 at the end of the stop bit, else IDLE.
REQ-017 SHALL pop the FIFO head on the edge entering START and latch it into a shift register.
REQ-018 SHALL assert tx_busy exactly while state != IDLE.
REQ-019 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL drive txd low starting after edge N+1.
- Pop is never performed on the byte being pushed in the same edge.
REQ-020 Back-to-back: consecutive queued bytes SHALL have no idle cycles between a stop bit and the next start bit.
- Frame period is exactly 10*CLKS_PER_BIT cycles.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged and store the pushed byte in FIFO order.
REQ-022 Full/wrap boundary conditions:
- When full, tx_ready=0.
- A pop while full SHALL raise tx_ready the following cycle.
- Read and write pointers SHALL wrap modulo FIFO_DEPTH with no data loss or duplication.
REQ-023 txd SHALL be high in IDLE and never glitch between bit boundaries.

Reset
REQ-024 arstn=0 SHALL immediately (asynchronously) force txd=1, tx_busy=0, fifo_count=0, tx_ready=1, FSM=IDLE, pointers=0.
REQ-025 Reset mid-frame SHALL abort the frame and discard queued bytes; after release, no transmission occurs until a new byte is accepted.
REQ-026 The first edge after arstn deasserts SHALL be able to accept a byte.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> CLKS_PER_BIT=10, FIFO_DEPTH=4)
REQ-027 Push 0xA5 once, idle -> txd low 1 cycle after accept for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high; tx_busy high 100 cycles.
REQ-028 Push 0x00,0xFF,0x55 back-to-back -> three frames, 300 contiguous busy cycles, no extra idle between stop and start bits, bytes received in order.
REQ-029 Hold tx_valid=1 continuously with 6 bytes -> fifo_count peaks at 4, tx_ready drops at full, reasserts one cycle after each pop, all 6 bytes sent in order.
REQ-030 Push at the same edge the FSM pops (count=2) -> fifo_count stays 2, order preserved.
REQ-031 Assert arstn=0 at cycle 45 of a frame with 2 bytes queued -> txd=1, tx_busy=0, fifo_count=0 immediately; line stays high after release until a new push.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a power-of-two byte FIFO feeding a
// start/data/stop serialiser with a registered, glitch-free line output.
module uart_tx_buffered #(
    parameter real CLK_FREQ   = 100_000_000.0,
    parameter int  BAUD_RATE  = 115_200,
    parameter int  FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = $rtoi(CLK_FREQ / BAUD_RATE + 0.5);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            push;
    logic            pop;
    logic            bit_done;

    assign tx_ready = (fifo_count < DEPTH_C);
    assign push     = tx_valid && tx_ready;
    assign bit_done = (baud_cnt == BIT_LAST);

    // Pop looks only at the registered count, so a byte pushed on this
    // edge can never be popped on the same edge.
    always_comb begin
        pop = 1'b0;
        if (fifo_count != '0) begin
            pop = (state == IDLE) || ((state == STOP) && bit_done);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        txd      <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state <= START;
                            shift <= mem[rd_ptr];
                            txd   <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
